mem_unload: RTL and testbench

- Read-back engine for the banked coefficient memory of the NTT/NWC core.
- When the core asserts DONE, top pulses start. The block then walks every bank/address through the memory's synchronous read port.
- Results stream out over a valid/ready interface to the result writer or host.
- It is the reader counterpart of the memory loader: it supports the same bank-major dump order and the natural coefficient order (index = addr*BN + bank).

---
 rtl/nwc_unload_pkg.sv | 27 ++
 rtl/unload_skid_fifo.sv | 41 ++++
 rtl/mem_unload.sv | 142 ++++++++++++++
 tb/tb_mem_unload.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nwc_unload_pkg.sv
// Shared types and sizing for the coefficient-memory unload engine.
// Beats carry their source bank/address so the sink can place them without counting.
package nwc_unload_pkg;

    localparam int D_WIDTH = 17;
    localparam int BN      = 16;
    localparam int MA      = 16;

    localparam int BANK_W  = $clog2(BN);
    localparam int ADDR_W  = $clog2(MA);
    localparam int TOTAL   = BN * MA;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [D_WIDTH-1:0] data;
        logic [BANK_W-1:0]  bank;
        logic [ADDR_W-1:0]  addr;
        logic               last;
    } beat_t;

endpackage

// File: rtl/unload_skid_fifo.sv
// Two-entry FIFO of beats sitting between the memory read return and the output stream.
// A push and a pop in the same cycle are allowed even when full: the popped slot is the one refilled.
module unload_skid_fifo
    import nwc_unload_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t store [2];
    logic  wr_ptr;
    logic  rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_beat;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/mem_unload.sv
// Read-back engine: walks every bank/address of the coefficient memory after the core finishes
// and streams the words out in bank-major or natural coefficient order over valid/ready.
module mem_unload
    import nwc_unload_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               order_sel,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [BANK_W-1:0]  rd_bank,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [BANK_W-1:0]  out_bank,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_last
);

    state_t              state;
    logic                order_q;
    logic [BANK_W-1:0]   bank_cnt;
    logic [ADDR_W-1:0]   addr_cnt;

    logic                rd_vld;
    logic [BANK_W-1:0]   tag_bank;
    logic [ADDR_W-1:0]   tag_addr;
    logic                tag_last;

    logic [1:0]          fifo_count;
    beat_t               head;
    beat_t               push_beat;
    logic                pop;
    logic                issue;
    logic                is_last_idx;
    logic [2:0]          used;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // A slot is free when buffered plus in-flight beats, less the one leaving now, is below two.
    assign used  = 3'(fifo_count) + 3'(rd_vld);
    assign issue = (state == RUN) && (used < (3'd2 + 3'(pop)));

    // Both orders end with every counter at its maximum, so one compare covers either walk.
    assign is_last_idx = ({bank_cnt, addr_cnt} == (BANK_W + ADDR_W)'(TOTAL - 1));

    assign rd_en   = issue;
    assign rd_bank = bank_cnt;
    assign rd_addr = addr_cnt;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == FIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            order_q  <= 1'b0;
            bank_cnt <= '0;
            addr_cnt <= '0;
            rd_vld   <= 1'b0;
            tag_bank <= '0;
            tag_addr <= '0;
            tag_last <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                tag_bank <= bank_cnt;
                tag_addr <= addr_cnt;
                tag_last <= is_last_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        order_q  <= order_sel;
                        bank_cnt <= '0;
                        addr_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (!order_q) begin
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                            if (&addr_cnt) begin
                                bank_cnt <= bank_cnt + BANK_W'(1);
                            end
                        end else begin
                            bank_cnt <= bank_cnt + BANK_W'(1);
                            if (&bank_cnt) begin
                                addr_cnt <= addr_cnt + ADDR_W'(1);
                            end
                        end
                        if (is_last_idx) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = rd_data;
        push_beat.bank = tag_bank;
        push_beat.addr = tag_addr;
        push_beat.last = tag_last;
    end

    unload_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_vld),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_data = head.data;
    assign out_bank = head.bank;
    assign out_addr = head.addr;
    assign out_last = head.last;

endmodule

// File: tb/tb_mem_unload.sv
// Bench for mem_unload: a behavioural memory with one-cycle read latency feeds the DUT,
// and each unload scenario from the vector table is run end to end against a reference beat order.
module tb_mem_unload;
    import nwc_unload_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               order_sel = 1'b0;
    logic               out_ready = 1'b0;
    logic [D_WIDTH-1:0] rd_data = '0;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [BANK_W-1:0]  rd_bank;
    logic [ADDR_W-1:0]  rd_addr;
    logic               out_valid;
    logic [D_WIDTH-1:0] out_data;
    logic [BANK_W-1:0]  out_bank;
    logic [ADDR_W-1:0]  out_addr;
    logic               out_last;

    logic [D_WIDTH-1:0] mem_model [BN][MA];

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        bit order;
        int stallLen;
        bit randReady;
        bit rePulse;
        int expFirstValid;
        int expDone;
        int expStallReads;
    } vec_t;

    vec_t vecs [5];

    mem_unload dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .order_sel (order_sel),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bank  (out_bank),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_model[rd_bank][rd_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit o, input bit r);
        start     = s;
        order_sel = o;
        out_ready = r;
    endtask

    task automatic runUnload(input vec_t v, input string tag);
        int   beat       = 0;
        int   firstValid = -1;
        int   doneCyc    = -1;
        int   stallReads = 0;
        int   issued     = 0;
        int   popped     = 0;
        int   maxOut     = 0;
        int   unstable   = 0;
        bit   pv         = 1'b0;
        bit   pr         = 1'b0;
        bit   r;
        bit   s;
        logic [25:0] prevTuple = '0;
        int   eb;
        int   ea;
        logic [25:0] expTuple;

        @(posedge clk);
        #1;
        applyStimulus(1'b1, v.order, v.randReady ? 1'($urandom_range(0, 1)) : (v.stallLen == 0));
        for (int c = 1; c < 2000 && doneCyc < 0; c++) begin
            @(posedge clk);
            #1;
            r = v.randReady ? 1'($urandom_range(0, 1)) : (c > v.stallLen);
            s = v.rePulse && (c == 50);
            applyStimulus(s, s ? ~v.order : v.order, r);
            @(negedge clk);
            if (c == 1) begin
                checkOutput({tag, "_busy_after_start"}, 64'(busy), 64'd1);
            end
            if (rd_en) begin
                issued++;
                if (c <= v.stallLen) stallReads++;
            end
            if (out_valid && firstValid < 0) firstValid = c;
            if (pv && !pr) begin
                if (!out_valid || {out_data, out_bank, out_addr, out_last} != prevTuple) unstable++;
            end
            if (out_valid && out_ready) begin
                eb = v.order ? (beat % 16) : (beat / 16);
                ea = v.order ? (beat / 16) : (beat % 16);
                expTuple = {17'(eb * 256 + ea), 4'(eb), 4'(ea), (beat == 255)};
                checkOutput($sformatf("%s_beat%0d", tag, beat),
                            64'({out_data, out_bank, out_addr, out_last}), 64'(expTuple));
                popped++;
                beat++;
            end
            if (issued - popped > maxOut) maxOut = issued - popped;
            if (v.stallLen > 0 && c == v.stallLen) begin
                checkOutput({tag, "_stalled_head"}, 64'({out_valid, out_data, out_bank, out_addr}),
                            64'({1'b1, 17'd0, 4'd0, 4'd0}));
            end
            if (done) begin
                doneCyc = c;
                checkOutput({tag, "_busy_in_done_cycle"}, 64'(busy), 64'd0);
            end
            pv = out_valid;
            pr = out_ready;
            prevTuple = {out_data, out_bank, out_addr, out_last};
        end
        checkOutput({tag, "_done_seen"}, 64'(doneCyc >= 0), 64'd1);
        checkOutput({tag, "_first_valid_cycle"}, 64'(firstValid), 64'(v.expFirstValid));
        if (v.expDone > 0) checkOutput({tag, "_done_cycle"}, 64'(doneCyc), 64'(v.expDone));
        checkOutput({tag, "_beat_count"}, 64'(beat), 64'd256);
        checkOutput({tag, "_unstable_holds"}, 64'(unstable), 64'd0);
        checkOutput({tag, "_max_outstanding"}, 64'(maxOut), 64'd2);
        if (v.stallLen > 0) checkOutput({tag, "_reads_during_stall"}, 64'(stallReads), 64'(v.expStallReads));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_idle_after_done"}, 64'({done, busy}), 64'd0);
    endtask

    initial begin
        int beats;
        bit hit;

        for (int b = 0; b < BN; b++) begin
            for (int a = 0; a < MA; a++) begin
                mem_model[b][a] = D_WIDTH'(b * 256 + a);
            end
        end

        // order, stallLen, randReady, rePulse, expFirstValid, expDone, expStallReads
        vecs[0] = '{1'b0, 0,  1'b0, 1'b0, 3, 259, 0};
        vecs[1] = '{1'b1, 0,  1'b0, 1'b0, 3, 259, 0};
        vecs[2] = '{1'b0, 10, 1'b0, 1'b0, 3, 267, 2};
        vecs[3] = '{1'b1, 0,  1'b1, 1'b0, 3, 0,   0};
        vecs[4] = '{1'b0, 0,  1'b0, 1'b1, 3, 259, 0};

        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_zero",
                    64'({busy, done, rd_en, rd_bank, rd_addr, out_valid, out_data, out_bank, out_addr, out_last}),
                    64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            runUnload(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(posedge clk);
        end

        // Mid-run reset once beat 100 has been accepted.
        beats = 0;
        hit   = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c < 400 && !hit; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (out_valid && out_ready) begin
                beats++;
                if (beats == 101) hit = 1'b1;
            end
        end
        checkOutput("midrun_beat100_reached", 64'(hit), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrun_reset_outputs_zero",
                    64'({busy, done, rd_en, rd_bank, rd_addr, out_valid, out_data, out_bank, out_addr, out_last}),
                    64'd0);
        repeat (2) @(posedge clk);
        runUnload(vecs[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
